// File: rtl/mid_update_pkg.sv
// rtl/mid_update_pkg.sv - shared types and constants for the mid-layer weight update block
package mid_update_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCALE,
    ST_MUL,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Lane index: 0, 1, 2 map directly; 3 stands for input X12.
  typedef logic [1:0] lane_t;

  typedef struct packed {
    logic  valid;
    lane_t lane;
  } lane_tag_t;

  localparam lane_t LANE_X12 = 2'd3;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_SUB_LAT  = 7;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fp_multiplier.sv
// rtl/fp_multiplier.sv - FP32 multiplier, round-to-nearest-even, denormals flushed to zero
module fp_multiplier #(
  parameter int LATENCY = 5
) (
  input  logic        clk_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0]        res;
  logic               sgn;
  logic [7:0]         ea, eb;
  logic [47:0]        prod;
  logic [24:0]        mant;
  logic               grd, stk;
  logic signed [9:0]  exp_v;
  logic [LATENCY-1:0][31:0] pipe_q;

  always_comb begin
    res   = 32'h0;
    sgn   = a_i[31] ^ b_i[31];
    ea    = a_i[30:23];
    eb    = b_i[30:23];
    prod  = {24'd0, 1'b1, a_i[22:0]} * {24'd0, 1'b1, b_i[22:0]};
    mant  = '0;
    grd   = 1'b0;
    stk   = 1'b0;
    exp_v = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if ((ea == 8'hFF && a_i[22:0] != '0) || (eb == 8'hFF && b_i[22:0] != '0)) begin
      res = QNAN;
    end else if (ea == 8'hFF || eb == 8'hFF) begin
      res = (ea == 8'h00 || eb == 8'h00) ? QNAN : {sgn, 8'hFF, 23'd0};
    end else if (ea == 8'h00 || eb == 8'h00) begin
      res = {sgn, 31'd0};
    end else begin
      if (prod[47]) begin
        mant  = {1'b0, prod[47:24]};
        grd   = prod[23];
        stk   = |prod[22:0];
        exp_v = exp_v + 10'sd1;
      end else begin
        mant = {1'b0, prod[46:23]};
        grd  = prod[22];
        stk  = |prod[21:0];
      end
      if (grd && (stk || mant[0])) begin
        mant = mant + 25'd1;
      end
      if (mant[24]) begin
        mant  = mant >> 1;
        exp_v = exp_v + 10'sd1;
      end
      if (exp_v <= 10'sd0) begin
        res = {sgn, 31'd0};
      end else if (exp_v >= 10'sd255) begin
        res = {sgn, 8'hFF, 23'd0};
      end else begin
        res = {sgn, exp_v[7:0], mant[22:0]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_q[0] <= res;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/fp_subtractor.sv
// rtl/fp_subtractor.sv - FP32 subtractor a - b, round-to-nearest-even, denormals flushed to zero
module fp_subtractor #(
  parameter int LATENCY = 7
) (
  input  logic        clk_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [31:0]        res, bn, big, sml;
  logic [7:0]         ea, eb, dexp;
  logic [26:0]        mb, ms, ms_sh, diff, norm;
  logic [27:0]        sum;
  logic [24:0]        mant;
  logic [4:0]         msb, lz;
  logic               is_zero;
  logic signed [9:0]  exp_v;
  logic [LATENCY-1:0][31:0] pipe_q;

  always_comb begin
    res     = 32'h0;
    bn      = {~b_i[31], b_i[30:0]};
    ea      = a_i[30:23];
    eb      = bn[30:23];
    big     = (bn[30:0] > a_i[30:0]) ? bn : a_i;
    sml     = (bn[30:0] > a_i[30:0]) ? a_i : bn;
    dexp    = big[30:23] - sml[30:23];
    mb      = {1'b1, big[22:0], 3'b000};
    ms      = {1'b1, sml[22:0], 3'b000};
    ms_sh   = '0;
    diff    = '0;
    sum     = '0;
    norm    = '0;
    mant    = '0;
    msb     = '0;
    lz      = '0;
    is_zero = 1'b0;
    exp_v   = $signed({2'b00, big[30:23]});
    if ((ea == 8'hFF && a_i[22:0] != '0) || (eb == 8'hFF && bn[22:0] != '0)) begin
      res = QNAN;
    end else if (ea == 8'hFF && eb == 8'hFF) begin
      res = (a_i[31] == bn[31]) ? a_i : QNAN;
    end else if (ea == 8'hFF || eb == 8'hFF) begin
      res = (ea == 8'hFF) ? a_i : bn;
    end else if (eb == 8'h00) begin
      res = a_i;
    end else if (ea == 8'h00) begin
      res = bn;
    end else begin
      // Bits shifted out of the smaller operand fold into a sticky LSB.
      if (dexp >= 8'd27) begin
        ms_sh = 27'd1;
      end else begin
        ms_sh    = ms >> dexp;
        ms_sh[0] = ms_sh[0] | (|(ms & ((27'd1 << dexp) - 27'd1)));
      end
      if (big[31] == sml[31]) begin
        sum = {1'b0, mb} + {1'b0, ms_sh};
        if (sum[27]) begin
          norm    = sum[27:1];
          norm[0] = norm[0] | sum[0];
          exp_v   = exp_v + 10'sd1;
        end else begin
          norm = sum[26:0];
        end
      end else begin
        diff = mb - ms_sh;
        if (diff == '0) begin
          is_zero = 1'b1;
        end
        for (int i = 0; i < 27; i++) begin
          if (diff[i]) begin
            msb = 5'(i);
          end
        end
        lz    = 5'd26 - msb;
        norm  = diff << lz;
        exp_v = exp_v - $signed({5'd0, lz});
      end
      mant = {1'b0, norm[26:3]};
      if (norm[2] && (norm[1] || norm[0] || norm[3])) begin
        mant = mant + 25'd1;
      end
      if (mant[24]) begin
        mant  = mant >> 1;
        exp_v = exp_v + 10'sd1;
      end
      if (is_zero) begin
        res = 32'h0;
      end else if (exp_v <= 10'sd0) begin
        res = {big[31], 31'd0};
      end else if (exp_v >= 10'sd255) begin
        res = {big[31], 8'hFF, 23'd0};
      end else begin
        res = {big[31], exp_v[7:0], mant[22:0]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    pipe_q[0] <= res;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/lane_tag_pipe.sv
// rtl/lane_tag_pipe.sv - fixed-depth {valid, lane} delay line that follows an arithmetic pipeline
module lane_tag_pipe
  import mid_update_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  valid_i,
  input  lane_t lane_i,
  output logic  valid_o,
  output lane_t lane_o
);

  lane_tag_t [DEPTH-1:0] pipe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= '{valid: valid_i, lane: lane_i};
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign valid_o = pipe_q[DEPTH-1].valid;
  assign lane_o  = pipe_q[DEPTH-1].lane;

endmodule

// File: rtl/mid_weight_update.sv
// rtl/mid_weight_update.sv - Wn = W - eta*delta*X for lanes 0,1,2,12 on one shared multiplier and subtractor
module mid_weight_update
  import mid_update_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int SUB_LAT  = DEF_SUB_LAT
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [31:0] iETA,
  input  logic [31:0] iDELTA,
  input  logic [31:0] iX0,
  input  logic [31:0] iX1,
  input  logic [31:0] iX2,
  input  logic [31:0] iX12,
  input  logic [31:0] iWEIGHT_V0,
  input  logic [31:0] iWEIGHT_V1,
  input  logic [31:0] iWEIGHT_V2,
  input  logic [31:0] iWEIGHT_V12,
  output logic [31:0] oWEIGHT_V0,
  output logic [31:0] oWEIGHT_V1,
  output logic [31:0] oWEIGHT_V2,
  output logic [31:0] oWEIGHT_V12,
  output logic        oBUSY,
  output logic        oDONE
);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [31:0]      eta_q, delta_q, k_q, k_d;
  logic [31:0]      hold_a_q, hold_b_q, mul_a, mul_b, mul_p, sub_a, sub_r;
  logic [3:0][31:0] x_q, w_q, wo_q;
  logic             latch;
  logic             mtag_in_valid, mtag_out_valid, stag_out_valid;
  lane_t            mtag_in_lane, mtag_out_lane, stag_out_lane;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    k_d           = k_q;
    mul_a         = hold_a_q;
    mul_b         = hold_b_q;
    mtag_in_valid = 1'b0;
    mtag_in_lane  = cnt_q[1:0];
    latch         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iSTART) begin
          latch   = 1'b1;
          cnt_d   = '0;
          state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        mul_a = eta_q;
        mul_b = delta_q;
        if (cnt_q == 8'(MULT_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ST_MUL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_MUL: begin
        // K arrives from the multiplier on the first MUL cycle; forward it while registering.
        mul_a         = (cnt_q == 8'd0) ? mul_p : k_q;
        mul_b         = x_q[cnt_q[1:0]];
        mtag_in_valid = 1'b1;
        if (cnt_q == 8'd0) begin
          k_d = mul_p;
        end
        if (cnt_q == 8'd3) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (stag_out_valid && stag_out_lane == LANE_X12) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      k_q      <= FP_ZERO;
      hold_a_q <= FP_ZERO;
      hold_b_q <= FP_ZERO;
      eta_q    <= FP_ZERO;
      delta_q  <= FP_ZERO;
      x_q      <= '0;
      w_q      <= '0;
      wo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      hold_a_q <= mul_a;
      hold_b_q <= mul_b;
      if (latch) begin
        eta_q   <= iETA;
        delta_q <= iDELTA;
        x_q     <= {iX12, iX2, iX1, iX0};
        w_q     <= {iWEIGHT_V12, iWEIGHT_V2, iWEIGHT_V1, iWEIGHT_V0};
      end
      if (stag_out_valid) begin
        wo_q[stag_out_lane] <= sub_r;
      end
    end
  end

  fp_multiplier #(.LATENCY(MULT_LAT)) u_mul (
    .clk_i    (iCLK),
    .a_i      (mul_a),
    .b_i      (mul_b),
    .result_o (mul_p)
  );

  lane_tag_pipe #(.DEPTH(MULT_LAT)) u_mul_tag (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .valid_i (mtag_in_valid),
    .lane_i  (mtag_in_lane),
    .valid_o (mtag_out_valid),
    .lane_o  (mtag_out_lane)
  );

  assign sub_a = w_q[mtag_out_lane];

  fp_subtractor #(.LATENCY(SUB_LAT)) u_sub (
    .clk_i    (iCLK),
    .a_i      (sub_a),
    .b_i      (mul_p),
    .result_o (sub_r)
  );

  lane_tag_pipe #(.DEPTH(SUB_LAT)) u_sub_tag (
    .clk_i   (iCLK),
    .rst_i   (iRST),
    .valid_i (mtag_out_valid),
    .lane_i  (mtag_out_lane),
    .valid_o (stag_out_valid),
    .lane_o  (stag_out_lane)
  );

  assign oWEIGHT_V0  = wo_q[0];
  assign oWEIGHT_V1  = wo_q[1];
  assign oWEIGHT_V2  = wo_q[2];
  assign oWEIGHT_V12 = wo_q[3];
  assign oBUSY       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign oDONE       = (state_q == ST_DONE);

endmodule

// File: tb/tb_mid_weight_update.sv
// tb/tb_mid_weight_update.sv - directed vector bench for mid_weight_update
module tb_mid_weight_update;
  import mid_update_pkg::*;

  localparam int LAT = 22;

  typedef struct {
    logic [31:0]      eta;
    logic [31:0]      delta;
    logic [3:0][31:0] x;
    logic [3:0][31:0] w;
    logic [3:0][31:0] ew;
  } vec_t;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iSTART = 1'b0;
  logic [31:0] iETA = '0, iDELTA = '0;
  logic [31:0] iX0 = '0, iX1 = '0, iX2 = '0, iX12 = '0;
  logic [31:0] iWEIGHT_V0 = '0, iWEIGHT_V1 = '0, iWEIGHT_V2 = '0, iWEIGHT_V12 = '0;
  logic [31:0] oWEIGHT_V0, oWEIGHT_V1, oWEIGHT_V2, oWEIGHT_V12;
  logic        oBUSY, oDONE;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[4];
  vec_t garbage;

  always #5 iCLK = ~iCLK;

  mid_weight_update dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iETA(iETA), .iDELTA(iDELTA),
    .iX0(iX0), .iX1(iX1), .iX2(iX2), .iX12(iX12),
    .iWEIGHT_V0(iWEIGHT_V0), .iWEIGHT_V1(iWEIGHT_V1),
    .iWEIGHT_V2(iWEIGHT_V2), .iWEIGHT_V12(iWEIGHT_V12),
    .oWEIGHT_V0(oWEIGHT_V0), .oWEIGHT_V1(oWEIGHT_V1),
    .oWEIGHT_V2(oWEIGHT_V2), .oWEIGHT_V12(oWEIGHT_V12),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  function automatic vec_t mk(input logic [31:0] eta, delta,
                              input logic [31:0] x0, x1, x2, x12,
                              input logic [31:0] w0, w1, w2, w12,
                              input logic [31:0] e0, e1, e2, e12);
    vec_t v;
    v.eta   = eta;
    v.delta = delta;
    v.x     = {x12, x2, x1, x0};
    v.w     = {w12, w2, w1, w0};
    v.ew    = {e12, e2, e1, e0};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_ops(input vec_t v);
    iETA = v.eta; iDELTA = v.delta;
    iX0 = v.x[0]; iX1 = v.x[1]; iX2 = v.x[2]; iX12 = v.x[3];
    iWEIGHT_V0 = v.w[0]; iWEIGHT_V1 = v.w[1]; iWEIGHT_V2 = v.w[2]; iWEIGHT_V12 = v.w[3];
  endtask

  task automatic check_weights(input string tag, input vec_t v);
    check({tag, " w0"},  oWEIGHT_V0,  v.ew[0]);
    check({tag, " w1"},  oWEIGHT_V1,  v.ew[1]);
    check({tag, " w2"},  oWEIGHT_V2,  v.ew[2]);
    check({tag, " w12"}, oWEIGHT_V12, v.ew[3]);
  endtask

  // One operation: start in cycle 0, optionally scramble inputs from cycle 1, expect oDONE at LAT.
  task automatic run_op(input string tag, input vec_t v, input bit perturb);
    int done_cyc;
    done_cyc = -1;
    @(posedge iCLK); #1;
    drive_ops(v);
    iSTART = 1'b1;
    @(negedge iCLK);
    check({tag, " busy c0"}, 32'(oBUSY), 32'd0);
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    if (perturb) drive_ops(garbage);
    for (int c = 1; c < 60; c++) begin
      @(negedge iCLK);
      if (c == 1) check({tag, " busy c1"}, 32'(oBUSY), 32'd1);
      if (oDONE) begin
        done_cyc = c;
        break;
      end
      @(posedge iCLK); #1;
    end
    check({tag, " done cycle"}, 32'(done_cyc), 32'(LAT));
    check({tag, " busy at done"}, 32'(oBUSY), 32'd0);
    check_weights(tag, v);
    @(posedge iCLK); #1;
    @(negedge iCLK);
    check({tag, " done pulse width"}, 32'(oDONE), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(32'h3F000000, FP_ONE,
                 FP_ONE, 32'h0, FP_ONE, FP_ONE,
                 FP_ONE, 32'h3F000000, 32'hBF000000, 32'h3E800000,
                 32'h3F000000, 32'h3F000000, 32'hBF800000, 32'hBE800000);
    vecs[1] = mk(32'h3E800000, 32'hC0000000,
                 FP_ONE, FP_ONE, FP_ONE, FP_ONE,
                 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000);
    vecs[2] = mk(FP_ZERO, 32'hC1200000,
                 32'h40490FDB, 32'hC2C80000, 32'h3DCCCCCD, 32'h47000000,
                 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000,
                 32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h3FC00000);
    vecs[3] = mk(FP_ONE, FP_ONE,
                 32'h40000000, FP_ONE, 32'h0, 32'hBF800000,
                 32'h40400000, 32'h0, FP_ONE, 32'h0,
                 FP_ONE, 32'hBF800000, FP_ONE, FP_ONE);
    garbage = mk(32'h40000000, 32'h40000000,
                 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                 32'h42000000, 32'h42000000, 32'h42000000, 32'h42000000,
                 32'h0, 32'h0, 32'h0, 32'h0);

    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    @(negedge iCLK);
    check("reset busy", 32'(oBUSY), 32'd0);
    check("reset done", 32'(oDONE), 32'd0);
    check_weights("reset", garbage);

    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // iSTART held for 40 cycles: accepted at 0 and 23 only.
    @(posedge iCLK); #1;
    drive_ops(vecs[3]);
    iSTART = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge iCLK);
      check($sformatf("held done c%0d", c), 32'(oDONE), 32'((c == 22) || (c == 45)));
      check($sformatf("held busy c%0d", c), 32'(oBUSY),
            32'(((c >= 1) && (c <= 21)) || ((c >= 24) && (c <= 44))));
      @(posedge iCLK); #1;
      if (c == 39) iSTART = 1'b0;
    end
    check_weights("held", vecs[3]);

    run_op("late change", vecs[0], 1'b1);

    // Reset in cycle 10 aborts; then a fresh start completes normally.
    begin
      int dones;
      dones = 0;
      @(posedge iCLK); #1;
      drive_ops(vecs[1]);
      iSTART = 1'b1;
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      repeat (9) begin @(posedge iCLK); #1; end
      iRST = 1'b1;
      @(posedge iCLK); #1;
      iRST = 1'b0;
      @(negedge iCLK);
      check("abort busy", 32'(oBUSY), 32'd0);
      check_weights("abort", garbage);
      for (int c = 11; c <= 40; c++) begin
        if (c > 11) @(negedge iCLK);
        if (oDONE) dones++;
        @(posedge iCLK); #1;
      end
      check("abort no done", 32'(dones), 32'd0);
    end
    run_op("after abort", vecs[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
